// File: rtl/data_memory_bx_pkg.sv
// Shared access-size codes and clear-FSM state encoding for the data memory.
// The size codes are also used by the control decoder.
package data_memory_bx_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;
endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for sub-word accesses: store merge, load extract/extend, misalign flag.
// Purely combinational; no backpressure.
module mem_lane_align
  import data_memory_bx_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_uns,
  input  logic [31:0] i_datain,
  input  logic [31:0] i_rd_word,
  output logic [31:0] o_wr_word,
  output logic [31:0] o_ld_data,
  output logic        o_misalign
);
  logic [3:0]  w_be;
  logic [31:0] w_wdat;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    w_be       = 4'b1111;
    w_wdat     = i_datain;
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        w_be   = 4'b0001 << i_lane;
        w_wdat = {4{i_datain[7:0]}};
      end
      SZ_HALF: begin
        w_be       = i_lane[1] ? 4'b1100 : 4'b0011;
        w_wdat     = {2{i_datain[15:0]}};
        o_misalign = i_lane[0];
      end
      default: o_misalign = (i_lane != 2'b00);
    endcase
  end

  always_comb begin
    o_wr_word = i_rd_word;
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) o_wr_word[8*b +: 8] = w_wdat[8*b +: 8];
    end
  end

  always_comb begin
    w_byte = i_rd_word[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_rd_word[31:16] : i_rd_word[15:0];
    case (i_size)
      SZ_BYTE: o_ld_data = {{24{~i_uns & w_byte[7]}}, w_byte};
      SZ_HALF: o_ld_data = {{16{~i_uns & w_half[15]}}, w_half};
      default: o_ld_data = i_rd_word;
    endcase
  end
endmodule

// File: rtl/data_memory_bx.sv
// Byte/half/word data memory with combinational reads, falling-edge writes and a zeroing sweep.
// Stores are silently dropped while busy; the CPU must honour busy.
module data_memory_bx
  import data_memory_bx_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int WORDS_LOG2 = 6
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              sclr,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       datain,
  input  logic              str,
  input  logic              ld,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] r_address,
  output logic [31:0]       dataout,
  output logic [31:0]       r_dataout,
  output logic              busy,
  output logic              misalign
);
  localparam int DEPTH = 2 ** WORDS_LOG2;

  logic [31:0]           r_mem [DEPTH];
  state_t                r_state;
  state_t                w_state_nxt;
  logic [WORDS_LOG2-1:0] r_cnt;
  logic [WORDS_LOG2-1:0] w_cnt_nxt;
  logic [WORDS_LOG2-1:0] w_idx;
  logic [WORDS_LOG2-1:0] w_ridx;
  logic [31:0]           w_wr_word;
  logic [31:0]           w_ld_data;
  logic                  w_unused_addr;

  assign w_idx  = address[WORDS_LOG2+1:2];
  assign w_ridx = r_address[WORDS_LOG2+1:2];
  assign w_unused_addr = ^{address[ADDR_W-1:WORDS_LOG2+2],
                           r_address[ADDR_W-1:WORDS_LOG2+2], r_address[1:0]};

  mem_lane_align u_align (
    .i_size     (size),
    .i_lane     (address[1:0]),
    .i_uns      (uns),
    .i_datain   (datain),
    .i_rd_word  (r_mem[w_idx]),
    .o_wr_word  (w_wr_word),
    .o_ld_data  (w_ld_data),
    .o_misalign (misalign)
  );

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_SWEEP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A soft clear in either state (re)starts the sweep from word 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (sclr) begin
          w_state_nxt = ST_SWEEP;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        if (sclr) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == '1) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (busy) begin
      r_mem[r_cnt] <= '0;
    end else if (str && !misalign) begin
      r_mem[w_idx] <= w_wr_word;
    end
  end

  assign busy      = (r_state == ST_SWEEP);
  assign dataout   = (ld && !busy && !misalign) ? w_ld_data : 32'h0;
  assign r_dataout = busy ? 32'h0 : r_mem[w_ridx];
endmodule

// File: tb/tb_data_memory_bx.sv
// Bench for data_memory_bx: vector table through a scoreboard queue, plus clear-sweep sequences.
module tb_data_memory_bx;
  import data_memory_bx_pkg::*;

  logic        clk = 1'b0;
  logic        clr, sclr, str, ld, uns;
  logic [11:0] address, r_address;
  logic [31:0] datain;
  logic [1:0]  size;
  logic [31:0] dataout, r_dataout;
  logic        busy, misalign;

  always #5 clk = ~clk;

  data_memory_bx dut (
    .clk(clk), .clr(clr), .sclr(sclr), .address(address), .datain(datain),
    .str(str), .ld(ld), .size(size), .uns(uns), .r_address(r_address),
    .dataout(dataout), .r_dataout(r_dataout), .busy(busy), .misalign(misalign)
  );

  typedef struct {
    logic        str, ld;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] din;
    logic [11:0] raddr;
    logic [31:0] e_dout;
    logic        e_mis;
    logic [31:0] e_rdat;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    logic        mis;
    logic [31:0] rdat;
  } exp_t;

  vec_t vt[23];
  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic s, l, input logic [1:0] sz, input logic u,
                              input logic [11:0] a, input logic [31:0] d, input logic [11:0] ra,
                              input logic [31:0] ed, input logic em, input logic [31:0] er);
    vec_t v;
    v.str = s; v.ld = l; v.size = sz; v.uns = u; v.addr = a; v.din = d; v.raddr = ra;
    v.e_dout = ed; v.e_mis = em; v.e_rdat = er;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    end
  endtask

  // Counts falling edges that occur while busy is high; bounded so a stuck sweep still ends.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      n++;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    exp_t e;

    //         str ld  size     uns addr     din           raddr    e_dout        mis e_rdat
    vt[0]  = mk(1, 0, SZ_WORD, 0, 12'h010, 32'h12345678, 12'h010, 32'h0,        0, 32'h0);
    vt[1]  = mk(0, 1, SZ_WORD, 0, 12'h010, 32'h0,        12'h010, 32'h12345678, 0, 32'h12345678);
    vt[2]  = mk(1, 0, SZ_BYTE, 0, 12'h011, 32'h000000AB, 12'h010, 32'h0,        0, 32'h12345678);
    vt[3]  = mk(0, 1, SZ_WORD, 0, 12'h010, 32'h0,        12'h010, 32'h1234AB78, 0, 32'h1234AB78);
    vt[4]  = mk(0, 1, SZ_BYTE, 0, 12'h011, 32'h0,        12'h010, 32'hFFFFFFAB, 0, 32'h1234AB78);
    vt[5]  = mk(0, 1, SZ_BYTE, 1, 12'h011, 32'h0,        12'h010, 32'h000000AB, 0, 32'h1234AB78);
    vt[6]  = mk(1, 0, SZ_HALF, 0, 12'h012, 32'h0000BEEF, 12'h010, 32'h0,        0, 32'h1234AB78);
    vt[7]  = mk(0, 1, SZ_WORD, 0, 12'h010, 32'h0,        12'h010, 32'hBEEFAB78, 0, 32'hBEEFAB78);
    vt[8]  = mk(0, 1, SZ_HALF, 0, 12'h012, 32'h0,        12'h010, 32'hFFFFBEEF, 0, 32'hBEEFAB78);
    vt[9]  = mk(0, 1, SZ_HALF, 1, 12'h012, 32'h0,        12'h010, 32'h0000BEEF, 0, 32'hBEEFAB78);
    vt[10] = mk(1, 1, SZ_WORD, 0, 12'h013, 32'hFFFFFFFF, 12'h010, 32'h0,        1, 32'hBEEFAB78);
    vt[11] = mk(0, 1, SZ_WORD, 0, 12'h010, 32'h0,        12'h010, 32'hBEEFAB78, 0, 32'hBEEFAB78);
    vt[12] = mk(1, 1, SZ_HALF, 0, 12'h011, 32'h0000FFFF, 12'h010, 32'h0,        1, 32'hBEEFAB78);
    vt[13] = mk(0, 1, SZ_BYTE, 0, 12'h013, 32'h0,        12'h010, 32'hFFFFFFBE, 0, 32'hBEEFAB78);
    vt[14] = mk(0, 1, SZ_BYTE, 0, 12'h010, 32'h0,        12'h010, 32'h00000078, 0, 32'hBEEFAB78);
    vt[15] = mk(0, 1, SZ_HALF, 0, 12'h010, 32'h0,        12'h010, 32'hFFFFAB78, 0, 32'hBEEFAB78);
    vt[16] = mk(1, 0, SZ_WORD, 0, 12'h100, 32'hCAFEF00D, 12'h000, 32'h0,        0, 32'h0);
    vt[17] = mk(0, 1, SZ_WORD, 0, 12'h000, 32'h0,        12'h100, 32'hCAFEF00D, 0, 32'hCAFEF00D);
    vt[18] = mk(1, 1, SZ_BYTE, 1, 12'h002, 32'h00000011, 12'h000, 32'h000000FE, 0, 32'hCAFEF00D);
    vt[19] = mk(0, 1, SZ_WORD, 0, 12'h000, 32'h0,        12'h000, 32'hCA11F00D, 0, 32'hCA11F00D);
    vt[20] = mk(1, 0, 2'b11,   0, 12'h004, 32'hA5A5A5A5, 12'h004, 32'h0,        0, 32'h0);
    vt[21] = mk(0, 1, 2'b11,   0, 12'h006, 32'h0,        12'h004, 32'h0,        1, 32'hA5A5A5A5);
    vt[22] = mk(0, 1, SZ_WORD, 0, 12'h004, 32'h0,        12'h004, 32'hA5A5A5A5, 0, 32'hA5A5A5A5);

    clr = 1'b1; sclr = 1'b0; str = 1'b0; ld = 1'b1; size = SZ_WORD; uns = 1'b0;
    address = 12'h0; datain = 32'h0; r_address = 12'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'h1);
    check("rst_dataout", dataout, 32'h0);
    check("rst_r_dataout", r_dataout, 32'h0);

    clr = 1'b0;
    count_busy(n);
    check("reset_sweep_edges", n, 32'd64);
    check("busy_after_sweep", {31'b0, busy}, 32'h0);
    ld = 1'b0; r_address = 12'h0FC;
    #1;
    check("r_dataout_0fc", r_dataout, 32'h0);

    for (int i = 0; i < 23; i++) begin
      str = vt[i].str; ld = vt[i].ld; size = vt[i].size; uns = vt[i].uns;
      address = vt[i].addr; datain = vt[i].din; r_address = vt[i].raddr;
      e.dout = vt[i].e_dout; e.mis = vt[i].e_mis; e.rdat = vt[i].e_rdat;
      sbq.push_back(e);
      #2;
      e = sbq.pop_front();
      check($sformatf("v%0d_dataout", i), dataout, e.dout);
      check($sformatf("v%0d_misalign", i), {31'b0, misalign}, {31'b0, e.mis});
      check($sformatf("v%0d_r_dataout", i), r_dataout, e.rdat);
      @(negedge clk); #1;
    end
    str = 1'b0; ld = 1'b0;

    // Soft clear, then a store to an already-swept word while busy must be dropped.
    sclr = 1'b1;
    @(negedge clk); #1;
    sclr = 1'b0;
    check("sclr_busy", {31'b0, busy}, 32'h1);
    repeat (20) @(negedge clk);
    #1;
    str = 1'b1; ld = 1'b1; size = SZ_WORD; address = 12'h020; datain = 32'h77777777;
    r_address = 12'h010;
    #1;
    check("busy_ld_masked", dataout, 32'h0);
    check("busy_r_dataout", r_dataout, 32'h0);
    @(negedge clk); #1;
    str = 1'b0;
    count_busy(n);
    check("sclr_remaining_edges", n, 32'd43);
    address = 12'h020;
    #1;
    check("dropped_store", dataout, 32'h0);
    address = 12'h010;
    #1;
    check("cleared_0x010", dataout, 32'h0);

    str = 1'b1; datain = 32'h55AA55AA;
    @(negedge clk); #1;
    str = 1'b0;
    check("restore_0x010", dataout, 32'h55AA55AA);

    // Re-pulse sclr at cnt=30.
    sclr = 1'b1;
    @(negedge clk); #1;
    sclr = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    sclr = 1'b1;
    @(negedge clk); #1;
    sclr = 1'b0;
    count_busy(n);
    check("resclr_edges", n, 32'd64);

    // clr from idle raises busy without any clock edge.
    @(posedge clk); #1;
    clr = 1'b1;
    #1;
    check("clr_async_busy", {31'b0, busy}, 32'h1);
    @(posedge clk); #1;
    clr = 1'b0;
    count_busy(n);
    check("clr_idle_edges", n, 32'd64);

    // clr mid-sweep restarts from word 0.
    sclr = 1'b1;
    @(negedge clk); #1;
    sclr = 1'b0;
    repeat (15) @(negedge clk);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    count_busy(n);
    check("clr_mid_sweep_edges", n, 32'd64);

    ld = 1'b1; size = SZ_WORD; address = 12'h010;
    #1;
    check("final_ld_0x010", dataout, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
